// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: mode encoding,
// the popcount helper and the filter counter width rule.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // Widest edge vector the popcount helper accepts; callers zero-extend.
  localparam int MAX_CHANNELS = 64;

  function automatic int unsigned popcount(input logic [MAX_CHANNELS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  function automatic int filt_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One channel: synchroniser, glitch filter, filt/filt_q registers and
// mode-gated rising/falling pulse generation.
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       level,
  input  logic [1:0] mode,
  output logic       p_edge,
  output logic       n_edge
);

  localparam int             CW       = filt_cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic                   filt;
  logic                   filt_q;
  mode_e                  mode_sel;
  logic                   rise_en;
  logic                   fall_en;

  assign s = sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync   <= '0;
      cnt    <= '0;
      filt   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], level};
      filt_q <= filt;
      if (s == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= ~filt;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Mode only gates the pulse; the filter above runs in every mode.
  assign mode_sel = mode_e'(mode);
  assign rise_en  = (mode_sel == MODE_RISE) || (mode_sel == MODE_BOTH);
  assign fall_en  = (mode_sel == MODE_FALL) || (mode_sel == MODE_BOTH);

  assign p_edge = filt & ~filt_q & rise_en;
  assign n_edge = ~filt & filt_q & fall_en;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel level-to-edge detector with sticky flags, combined irq
// and a saturating event counter. CHANNELS must not exceed 64.
module multi_edge_detector
  import edge_pkg::*;
#(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   level,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  input  logic                  count_clr,
  output logic [CHANNELS-1:0]   p_edge,
  output logic [CHANNELS-1:0]   n_edge,
  output logic [CHANNELS-1:0]   edge_detected,
  output logic [CHANNELS-1:0]   event_flags,
  output logic                  irq,
  output logic [CNT_W-1:0]      event_count
);

  localparam int               PC_W    = $clog2(CHANNELS + 1);
  localparam int               SUM_W   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PC_W-1:0]  hits;
  logic [SUM_W-1:0] total;
  logic [CNT_W-1:0] count_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .level  (level[i]),
      .mode   (mode[2*i+1:2*i]),
      .p_edge (p_edge[i]),
      .n_edge (n_edge[i])
    );
  end

  assign edge_detected = p_edge | n_edge;
  assign irq           = |event_flags;

  // A clear loads this cycle's hits rather than zero so concurrent events
  // are never dropped; the wide sum makes saturation a simple compare.
  // NOTE: every always_comb output is assigned on every path, so no latch.
  always_comb begin
    hits       = PC_W'(popcount(MAX_CHANNELS'(edge_detected)));
    total      = (count_clr ? '0 : SUM_W'(event_count)) + SUM_W'(hits);
    count_next = (total > SUM_W'(CNT_MAX)) ? CNT_MAX : total[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_flags <= '0;
      event_count <= '0;
    end else begin
      event_flags <= (event_flags & ~clear) | edge_detected;
      event_count <= count_next;
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench: a window-based behavioural model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_multi_edge_detector;

  localparam int CH   = 8;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int CW   = 4;
  localparam int CMAX = 2**CW - 1;

  logic            clk       = 1'b0;
  logic            reset     = 1'b1;
  logic [CH-1:0]   level     = '0;
  logic [2*CH-1:0] mode      = '1;
  logic [CH-1:0]   clear     = '0;
  logic            count_clr = 1'b0;
  logic [CH-1:0]   p_edge;
  logic [CH-1:0]   n_edge;
  logic [CH-1:0]   edge_detected;
  logic [CH-1:0]   event_flags;
  logic            irq;
  logic [CW-1:0]   event_count;

  always #5 clk = ~clk;

  multi_edge_detector #(
    .CHANNELS      (CH),
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .CNT_W         (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .level         (level),
    .mode          (mode),
    .clear         (clear),
    .count_clr     (count_clr),
    .p_edge        (p_edge),
    .n_edge        (n_edge),
    .edge_detected (edge_detected),
    .event_flags   (event_flags),
    .irq           (irq),
    .event_count   (event_count)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the synchronised level is the raw level SYNC samples ago; a
  // filtered level flips once FILT consecutive synchronised samples disagree.
  logic [CH-1:0] hist [SYNC+FILT];
  logic [CH-1:0] mfilt   = '0;
  logic [CH-1:0] mfilt_q = '0;
  logic [CH-1:0] mflags  = '0;
  int            mcount  = 0;

  function automatic logic [CH-1:0] rise_mask();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = mode[2*i];
    return r;
  endfunction

  function automatic logic [CH-1:0] fall_mask();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = mode[2*i+1];
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_p();
    return mfilt & ~mfilt_q & rise_mask();
  endfunction

  function automatic logic [CH-1:0] exp_n();
    return ~mfilt & mfilt_q & fall_mask();
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [CH-1:0] ed;
    int            tot;
    bit            all_diff;
    if (reset) begin
      for (int k = 0; k < SYNC + FILT; k++) hist[k] = '0;
      mfilt = '0; mfilt_q = '0; mflags = '0; mcount = 0;
    end else begin
      ed     = exp_p() | exp_n();
      mflags = (mflags & ~clear) | ed;
      tot    = (count_clr ? 0 : mcount) + $countones(ed);
      mcount = (tot > CMAX) ? CMAX : tot;
      for (int k = SYNC + FILT - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = level;
      mfilt_q = mfilt;
      for (int c = 0; c < CH; c++) begin
        all_diff = 1'b1;
        for (int k = SYNC; k < SYNC + FILT; k++)
          if (hist[k][c] == mfilt[c]) all_diff = 1'b0;
        if (all_diff) mfilt[c] = ~mfilt[c];
      end
    end
  end

  always @(negedge clk) begin
    check("p_edge",        32'(p_edge),        32'(exp_p()));
    check("n_edge",        32'(n_edge),        32'(exp_n()));
    check("edge_detected", 32'(edge_detected), 32'(exp_p() | exp_n()));
    check("event_flags",   32'(event_flags),   32'(mflags));
    check("irq",           32'(irq),           32'(|mflags));
    check("event_count",   32'(event_count),   32'(mcount));
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear(input logic [CH-1:0] m);
    clear = m; step(1); clear = '0;
  endtask

  task automatic pulse_count_clr();
    count_clr = 1'b1; step(1); count_clr = 1'b0;
  endtask

  initial begin
    mode[1:0] = 2'b01;
    mode[5:4] = 2'b10;
    step(2);
    check("reset_count", 32'(event_count), 0);
    check("reset_flags", 32'(event_flags), 0);
    check("reset_irq",   32'(irq),         0);
    reset = 1'b0;
    step(2);

    // Single rising edge on channel 0.
    level[0] = 1'b1;
    step(5);
    check("t1_no_early_pulse", 32'(p_edge), 0);
    step(1);
    check("t1_pulse", 32'(p_edge), 32'h01);
    check("t1_flag_not_yet", 32'(event_flags), 0);
    step(1);
    check("t1_pulse_gone", 32'(p_edge), 0);
    check("t1_flag", 32'(event_flags), 32'h01);
    check("t1_irq", 32'(irq), 1);
    check("t1_count", 32'(event_count), 1);
    level[0] = 1'b0;
    step(10);
    check("t1_fall_gated", 32'(event_count), 1);
    pulse_clear('1);
    check("t1_cleared", 32'(event_flags), 0);

    // Glitch rejection on channel 1.
    pulse_count_clr();
    level[1] = 1'b1; step(3); level[1] = 1'b0;
    step(12);
    check("t2_glitch_count", 32'(event_count), 0);
    check("t2_glitch_flag", 32'(event_flags), 0);
    level[1] = 1'b1; step(4); level[1] = 1'b0;
    step(14);
    check("t2_pulse_count", 32'(event_count), 2);
    check("t2_pulse_flag", 32'(event_flags), 32'h02);
    pulse_clear('1);

    // Mode gating on channel 2.
    pulse_count_clr();
    level[2] = 1'b1; step(10);
    level[2] = 1'b0; step(10);
    check("t3_fall_only", 32'(event_count), 1);
    check("t3_flag", 32'(event_flags), 32'h04);
    mode[5:4] = 2'b00;
    level[2] = 1'b1; step(10);
    level[2] = 1'b0; step(10);
    check("t3_off_count", 32'(event_count), 1);
    level[2] = 1'b1; step(10);
    mode[5:4] = 2'b11;
    step(3);
    check("t3_mode_switch_no_pulse", 32'(edge_detected), 0);
    step(5);
    check("t3_mode_switch_count", 32'(event_count), 1);
    level[2] = 1'b0; step(10);
    check("t3_both_fall", 32'(event_count), 2);
    pulse_clear('1);

    // Set/clear collision on channel 3.
    level[3] = 1'b1;
    step(6);
    check("t4_pulse", 32'(p_edge), 32'h08);
    clear = 8'h08; step(1); clear = '0;
    check("t4_set_wins", 32'(event_flags), 32'h08);
    pulse_clear(8'h08);
    check("t4_cleared", 32'(event_flags), 0);
    check("t4_irq_low", 32'(irq), 0);
    level[3] = 1'b0; step(10);
    pulse_clear('1);

    // Counter saturation and count_clr with concurrent events.
    pulse_count_clr();
    level = '1; step(10);
    check("t5_all_rise", 32'(event_count), 8);
    level = '0; step(10);
    check("t5_saturate", 32'(event_count), 15);
    level = '1; step(10);
    check("t5_stay_sat", 32'(event_count), 15);
    level = '0; step(10);
    level = '1;
    step(6);
    check("t5_all_pulse", 32'(edge_detected), 32'hFF);
    count_clr = 1'b1; step(1); count_clr = 1'b0;
    check("t5_clr_with_events", 32'(event_count), 8);

    // Reset mid-filter, then level high at release.
    level = '0;
    step(4);
    reset = 1'b1;
    #1;
    check("t6_count_zero", 32'(event_count), 0);
    check("t6_flags_zero", 32'(event_flags), 0);
    check("t6_irq_zero", 32'(irq), 0);
    check("t6_edges_zero", 32'(edge_detected), 0);
    step(2);
    reset = 1'b0;
    step(12);
    check("t6_no_pulse_after", 32'(event_count), 0);
    reset = 1'b1;
    level = '1;
    step(2);
    reset = 1'b0;
    step(5);
    check("t7_no_early", 32'(p_edge), 0);
    step(1);
    check("t7_rise_pulse", 32'(p_edge), 32'hFF);
    step(1);
    check("t7_count", 32'(event_count), 8);
    check("t7_flags", 32'(event_flags), 32'hFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
